// File: rtl/femto_lbus_bridge_if.sv
// femto_lbus_bridge_if: FemtoRV32 native bus plus register-file local bus signals
interface femto_lbus_bridge_if;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb, mem_rbusy, mem_wbusy;
  logic [31:0] lb_waddr, lb_wdata, lb_raddr, lb_rdata;
  logic [3:0]  lb_wstrb;
  logic        lb_wen, lb_wready, lb_ren, lb_rvalid;
  modport slave (
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb, lb_wready, lb_rdata, lb_rvalid,
    output mem_rdata, mem_rbusy, mem_wbusy, lb_waddr, lb_wdata, lb_wstrb, lb_wen, lb_raddr, lb_ren
  );
  modport master (
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb, lb_wready, lb_rdata, lb_rvalid,
    input  mem_rdata, mem_rbusy, mem_wbusy, lb_waddr, lb_wdata, lb_wstrb, lb_wen, lb_raddr, lb_ren
  );
endinterface

// File: rtl/femto_lbus_bridge.sv
// femto_lbus_bridge: one core access becomes one local-bus request, with busy stall and timeout
module femto_lbus_bridge #(
  parameter logic [31:0] ADDR_MASK = 32'h0FFF_FFFF,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic clk,
  input  logic rst,
  femto_lbus_bridge_if.slave bus,
  input  logic err_clr,
  output logic timeout_err
);
  // state bits double as the busy/request flops
  typedef enum logic [1:0] {IDLE = 2'b00, RD = 2'b01, WR = 2'b10} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_waddr, r_wdata, r_raddr, r_rdata;
  logic [3:0]  r_wstrb;
  logic        r_err, w_resp, w_tmo, w_wreq, w_rreq;
  assign w_wreq = r_state == IDLE && |bus.mem_wmask;
  assign w_rreq = r_state == IDLE && !(|bus.mem_wmask) && bus.mem_rstrb;
  assign w_resp = (r_state == RD && bus.lb_rvalid) || (r_state == WR && bus.lb_wready);
  assign w_tmo  = r_state != IDLE && !w_resp && r_cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb
    w_next = w_wreq ? WR : w_rreq ? RD : (w_resp || w_tmo) ? IDLE : r_state;
  always_comb begin
    bus.lb_wen    = r_state == WR;
    bus.mem_wbusy = r_state == WR;
    bus.lb_ren    = r_state == RD;
    bus.mem_rbusy = r_state == RD;
    bus.lb_waddr  = r_waddr;
    bus.lb_wdata  = r_wdata;
    bus.lb_wstrb  = r_wstrb;
    bus.lb_raddr  = r_raddr;
    bus.mem_rdata = r_rdata;
    timeout_err   = r_err;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_raddr <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_cnt <= (r_state == IDLE || w_next == IDLE) ? 8'd0 : r_cnt + 8'd1;
      if (w_wreq) begin
        r_waddr <= bus.mem_addr & ADDR_MASK;
        r_wdata <= bus.mem_wdata;
        r_wstrb <= bus.mem_wmask;
      end
      if (w_rreq) r_raddr <= bus.mem_addr & ADDR_MASK;
      if (r_state == RD && w_resp) r_rdata <= bus.lb_rdata;
      else if (r_state == RD && w_tmo) r_rdata <= ERR_DATA;
      r_err <= w_tmo ? 1'b1 : err_clr ? 1'b0 : r_err;
    end
endmodule

// File: tb/tb_femto_lbus_bridge.sv
// tb_femto_lbus_bridge: directed and random transactions against a transaction-level model
module tb_femto_lbus_bridge;
  localparam int          TO   = 16;
  localparam logic [31:0] MASK = 32'h0FFF_FFFF;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  logic clk = 0, rst = 1, err_clr = 0, timeout_err;
  femto_lbus_bridge_if bus ();
  femto_lbus_bridge #(.ADDR_MASK(MASK), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_clr(err_clr), .timeout_err(timeout_err));
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  logic [31:0] exp_rdata = 0;
  logic        exp_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  // lat = busy cycle index (0-based) in which the responder answers
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input int lat, input bit also_rd);
    int n;
    logic [31:0] rv;
    rv = $urandom;
    tick();
    bus.mem_addr = a; bus.mem_wdata = d;
    bus.mem_wmask = wr ? m : 4'h0;
    bus.mem_rstrb = wr ? also_rd : 1'b1;
    tick();
    bus.mem_wmask = 0; bus.mem_rstrb = 0;
    chk("wen_rise", 32'(bus.lb_wen), 32'(wr));
    chk("ren_rise", 32'(bus.lb_ren), 32'(!wr));
    if (wr) begin
      chk("waddr", bus.lb_waddr, a & MASK);
      chk("wdata", bus.lb_wdata, d);
      chk("wstrb", 32'(bus.lb_wstrb), 32'(m));
    end else chk("raddr", bus.lb_raddr, a & MASK);
    n = 0;
    while ((bus.mem_rbusy || bus.mem_wbusy) && n < 300) begin
      chk("req_vs_busy", {30'd0, bus.lb_wen, bus.lb_ren}, {30'd0, bus.mem_wbusy, bus.mem_rbusy});
      if (wr) begin
        bus.lb_wready = (n == lat);
        bus.lb_rvalid = $urandom_range(0, 1);
        bus.lb_rdata = $urandom;
      end else begin
        bus.lb_rvalid = (n == lat);
        bus.lb_wready = $urandom_range(0, 1);
        bus.lb_rdata = (n == lat) ? rv : $urandom;
      end
      tick();
      n++;
      bus.lb_wready = 0; bus.lb_rvalid = 0;
    end
    if (lat >= TO) exp_err = 1;
    if (!wr) exp_rdata = (lat >= TO) ? ERRD : rv;
    chk(wr ? "wbusy_len" : "rbusy_len", 32'(n), 32'(lat < TO ? lat + 1 : TO));
    chk("rdata", bus.mem_rdata, exp_rdata);
    chk("timeout_err", 32'(timeout_err), 32'(exp_err));
  endtask
  task automatic clear_err();
    err_clr = 1; tick(); err_clr = 0;
    exp_err = 0;
    chk("err_clr", 32'(timeout_err), 32'(exp_err));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.mem_addr = 0; bus.mem_wdata = 0; bus.mem_wmask = 0; bus.mem_rstrb = 0;
    bus.lb_wready = 0; bus.lb_rvalid = 0; bus.lb_rdata = 0;
    repeat (2) tick();
    chk("rst_outs", {bus.lb_wen, bus.lb_ren, bus.mem_rbusy, bus.mem_wbusy, timeout_err}, 32'd0);
    chk("rst_rdata", bus.mem_rdata, 0);
    chk("rst_waddr", bus.lb_waddr | bus.lb_raddr | bus.lb_wdata | 32'(bus.lb_wstrb), 0);
    rst = 0;
    txn(1, 32'h2000_0004, 32'hA5A5_0F0F, 4'hF, 0, 0);
    txn(0, 32'h2000_0008, 0, 0, 3, 0);
    txn(0, 32'h2000_000C, 0, 0, 1000, 0);
    clear_err();
    txn(1, 32'hF123_4560, 32'h1234_5678, 4'h3, 2, 1);
    txn(0, 32'h3000_0010, 0, 0, TO - 1, 0);
    txn(1, 32'h3000_0014, 32'h0BAD_F00D, 4'h8, TO - 1, 0);
    txn(1, 32'h3000_0018, 32'h5555_AAAA, 4'h1, TO, 0);
    clear_err();
    for (int i = 0; i < 40; i++) begin
      txn($urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(1, 15)),
          $urandom_range(0, TO + 3), $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) clear_err();
    end
    txn(0, 32'h2000_0020, 0, 0, 1000, 0);
    tick();
    bus.mem_addr = 32'h2000_0024; bus.mem_rstrb = 1;
    tick();
    bus.mem_rstrb = 0;
    tick();
    rst = 1;
    #1;
    chk("arst_ren", 32'(bus.lb_ren), 0);
    chk("arst_rbusy", 32'(bus.mem_rbusy), 0);
    chk("arst_rdata", bus.mem_rdata, 0);
    chk("arst_err", 32'(timeout_err), 0);
    tick();
    rst = 0;
    exp_rdata = 0; exp_err = 0;
    bus.lb_rvalid = 1; bus.lb_rdata = 32'h1357_9BDF; bus.lb_wready = 1;
    repeat (2) tick();
    bus.lb_rvalid = 0; bus.lb_wready = 0;
    chk("late_rbusy", {bus.mem_rbusy, bus.lb_ren, bus.mem_wbusy, bus.lb_wen}, 0);
    chk("late_rdata", bus.mem_rdata, exp_rdata);
    txn(0, 32'h2000_0028, 0, 0, 5, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
